// File: rtl/cluster_pwr_seq_if.sv
// Command-side handshake bundle between the SoC control registers and cluster_pwr_seq.
// The master is the command source and the slave is the sequencer.
interface cluster_pwr_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_on;
    logic [63:0] cmd_boot_addr;
    logic        cmd_byp;
    logic        done;
    logic        err;
    logic [2:0]  state;

    modport master (
        output cmd_valid, cmd_on, cmd_boot_addr, cmd_byp,
        input  cmd_ready, done, err, state
    );

    modport slave (
        input  cmd_valid, cmd_on, cmd_boot_addr, cmd_byp,
        output cmd_ready, done, err, state
    );
endinterface

// File: rtl/cluster_pwr_seq.sv
// Cluster power sequencer: power-up, clock enable, reset release, boot, drain and power-down.
// Define CLUSTER_PWR_ACK_EN to gate the power steps on cluster_pow_ack_i instead of the settle counter.
module cluster_pwr_seq #(
    parameter logic [63:0] BOOT_ADDR_DEFAULT = 64'h1C008080,
    parameter int          PWR_SETTLE_CYCLES = 16,
    parameter int          RST_HOLD_CYCLES   = 8,
    parameter int          DRAIN_TIMEOUT     = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    cluster_pwr_seq_if.slave         cmd,
    input  logic                     cluster_busy_i,
    input  logic                     cluster_pow_ack_i,
    output logic                     cluster_pow_o,
    output logic                     cluster_byp_o,
    output logic                     cluster_clk_en_o,
    output logic                     cluster_rstn_o,
    output logic                     cluster_fetch_enable_o,
    output logic [63:0]              cluster_boot_addr_o
);

    localparam int MAX_A   = (PWR_SETTLE_CYCLES > RST_HOLD_CYCLES) ? PWR_SETTLE_CYCLES : RST_HOLD_CYCLES;
    localparam int MAX_CNT = (MAX_A > DRAIN_TIMEOUT) ? MAX_A : DRAIN_TIMEOUT;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(PWR_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_OFF        = 3'd0,
        S_PWR_UP     = 3'd1,
        S_RST_HOLD   = 3'd2,
        S_RUN        = 3'd3,
        S_DRAIN      = 3'd4,
        S_RST_ASSERT = 3'd5,
        S_PWR_DOWN   = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drain_idle_q, drain_idle_d;
    logic [63:0]       boot_addr_q, boot_addr_d;
    logic              byp_q, byp_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              pow_q, pow_d;
    logic              clk_en_q, clk_en_d;
    logic              rstn_q, rstn_d;
    logic              fetch_q, fetch_d;
    logic              ready;
    logic              accept;

    assign ready  = (state_q == S_OFF) || (state_q == S_RUN);
    assign accept = cmd.cmd_valid && ready;

`ifndef CLUSTER_PWR_ACK_EN
    logic unused_pow_ack;
    assign unused_pow_ack = cluster_pow_ack_i;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        drain_idle_d = 1'b0;
        boot_addr_d  = boot_addr_q;
        byp_d        = byp_q;
        err_d        = err_q;
        done_d       = 1'b0;

        case (state_q)
            S_OFF: begin
                if (accept) begin
                    err_d = 1'b0;
                    if (cmd.cmd_on) begin
                        boot_addr_d = cmd.cmd_boot_addr;
                        byp_d       = cmd.cmd_byp;
                        state_d     = S_PWR_UP;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_PWR_UP: begin
`ifdef CLUSTER_PWR_ACK_EN
                if (cluster_pow_ack_i) begin
                    state_d = S_RST_HOLD;
                end else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_RST_HOLD;
                end
`else
                if (cnt_q == '0) state_d = S_RST_HOLD;
`endif
            end
            S_RST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_RUN;
                    done_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (accept) begin
                    err_d = 1'b0;
                    if (cmd.cmd_on) done_d  = 1'b1;
                    else            state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Busy seen low at one edge arms the exit taken at the following edge.
                drain_idle_d = !cluster_busy_i;
                if (drain_idle_q) begin
                    state_d = S_RST_ASSERT;
                end else if ((cnt_q == '0) && cluster_busy_i) begin
                    err_d   = 1'b1;
                    state_d = S_RST_ASSERT;
                end
            end
            S_RST_ASSERT: begin
                state_d = S_PWR_DOWN;
            end
            S_PWR_DOWN: begin
`ifdef CLUSTER_PWR_ACK_EN
                if (!cluster_pow_ack_i) begin
                    state_d = S_OFF;
                    done_d  = 1'b1;
                end else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_OFF;
                    done_d  = 1'b1;
                end
`else
                if (cnt_q == '0) begin
                    state_d = S_OFF;
                    done_d  = 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_OFF;
            end
        endcase

        if (state_d != state_q) begin
            case (state_d)
`ifdef CLUSTER_PWR_ACK_EN
                S_PWR_UP:   cnt_d = DRAIN_LD;
                S_PWR_DOWN: cnt_d = DRAIN_LD;
`else
                S_PWR_UP:   cnt_d = SETTLE_LD;
                S_PWR_DOWN: cnt_d = SETTLE_LD;
`endif
                S_RST_HOLD: cnt_d = HOLD_LD;
                S_DRAIN:    cnt_d = DRAIN_LD;
                default:    cnt_d = '0;
            endcase
        end

        // Cluster pins are decoded from the next state so they flip on the same edge as state_q.
        pow_d    = (state_d == S_PWR_UP) || (state_d == S_RST_HOLD) || (state_d == S_RUN) ||
                   (state_d == S_DRAIN)  || (state_d == S_RST_ASSERT);
        clk_en_d = (state_d == S_RST_HOLD) || (state_d == S_RUN) ||
                   (state_d == S_DRAIN)    || (state_d == S_RST_ASSERT);
        rstn_d   = (state_d == S_RUN) || (state_d == S_DRAIN);
        fetch_d  = (state_d == S_RUN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_OFF;
            cnt_q        <= '0;
            drain_idle_q <= 1'b0;
            boot_addr_q  <= BOOT_ADDR_DEFAULT;
            byp_q        <= 1'b0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            pow_q        <= 1'b0;
            clk_en_q     <= 1'b0;
            rstn_q       <= 1'b0;
            fetch_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            drain_idle_q <= drain_idle_d;
            boot_addr_q  <= boot_addr_d;
            byp_q        <= byp_d;
            err_q        <= err_d;
            done_q       <= done_d;
            pow_q        <= pow_d;
            clk_en_q     <= clk_en_d;
            rstn_q       <= rstn_d;
            fetch_q      <= fetch_d;
        end
    end

    assign cmd.cmd_ready          = ready;
    assign cmd.done               = done_q;
    assign cmd.err                = err_q;
    assign cmd.state              = state_q;
    assign cluster_pow_o          = pow_q;
    assign cluster_byp_o          = byp_q;
    assign cluster_clk_en_o       = clk_en_q;
    assign cluster_rstn_o         = rstn_q;
    assign cluster_fetch_enable_o = fetch_q;
    assign cluster_boot_addr_o    = boot_addr_q;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// Scoreboard bench for cluster_pwr_seq: every change of the observed output vector is matched,
// in order and by cycle, against expectations queued by the stimulus process.
module tb_cluster_pwr_seq;

    localparam logic [63:0] ADDR_DEF = 64'h1C008080;
    localparam logic [63:0] ADDR_A   = 64'h1C000000;
    localparam logic [63:0] ADDR_B   = 64'h1C008000;
    localparam logic [63:0] ADDR_C   = 64'h1C010000;

    logic        clk;
    logic        rst;
    logic        busy;
    logic        pow_ack;
    logic        pow, byp, clk_en, rstn, fetch;
    logic [63:0] boot_addr;

    cluster_pwr_seq_if ifc ();

    cluster_pwr_seq dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .cmd                    (ifc),
        .cluster_busy_i         (busy),
        .cluster_pow_ack_i      (pow_ack),
        .cluster_pow_o          (pow),
        .cluster_byp_o          (byp),
        .cluster_clk_en_o       (clk_en),
        .cluster_rstn_o         (rstn),
        .cluster_fetch_enable_o (fetch),
        .cluster_boot_addr_o    (boot_addr)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic        rdy;
        logic        pow;
        logic        clk_en;
        logic        rstn;
        logic        fetch;
        logic        byp;
        logic        done;
        logic        err;
        logic [63:0] addr;
    } snap_t;

    typedef struct {
        int    cyc;
        snap_t s;
    } exp_t;

    exp_t        q[$];
    snap_t       prev;
    int          cyc;
    int          n_checks;
    int          n_pass;
    bit          mon_en;
    logic [63:0] e_addr;
    logic        e_byp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic snap_t snap();
        snap_t s;
        s.st     = ifc.state;
        s.rdy    = ifc.cmd_ready;
        s.pow    = pow;
        s.clk_en = clk_en;
        s.rstn   = rstn;
        s.fetch  = fetch;
        s.byp    = byp;
        s.done   = ifc.done;
        s.err    = ifc.err;
        s.addr   = boot_addr;
        return s;
    endfunction

    // Expected pin levels per state, straight from the state table.
    function automatic snap_t mk(input logic [2:0] st, input logic d, input logic e);
        snap_t s;
        s.st     = st;
        s.rdy    = (st == 3'd0) || (st == 3'd3);
        s.pow    = (st >= 3'd1) && (st <= 3'd5);
        s.clk_en = (st >= 3'd2) && (st <= 3'd5);
        s.rstn   = (st == 3'd3) || (st == 3'd4);
        s.fetch  = (st == 3'd3);
        s.byp    = e_byp;
        s.done   = d;
        s.err    = e;
        s.addr   = e_addr;
        return s;
    endfunction

    task automatic push(input int c, input logic [2:0] st, input logic d, input logic e);
        exp_t x;
        x.cyc = c;
        x.s   = mk(st, d, e);
        q.push_back(x);
    endtask

    // Offers a command until accepted; returns the cycle stamp of spec cycle 1 after acceptance.
    task automatic issue(input logic on, input logic [63:0] addr, input logic b, output int base);
        int k;
        @(negedge clk);
        ifc.cmd_valid     = 1'b1;
        ifc.cmd_on        = on;
        ifc.cmd_boot_addr = addr;
        ifc.cmd_byp       = b;
        k = 0;
        while (!ifc.cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!ifc.cmd_ready) begin
            n_checks++;
            $display("FAIL cmd_accept: ready=%0b after %0d cycles, required 1", ifc.cmd_ready, k);
        end
        @(posedge clk);
        #1;
        ifc.cmd_valid = 1'b0;
        base = cyc;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            snap_t cur;
            cur = snap();
            if (cur !== prev) begin
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_change: cyc=%0d got=%h, required no change", cyc, cur);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    if (x.cyc == cyc && x.s === cur) n_pass++;
                    else $display("FAIL seq_step: cyc=%0d got=%h, required cyc=%0d val=%h",
                                  cyc, cur, x.cyc, x.s);
                end
                prev = cur;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        n_checks = 0;
        n_pass   = 0;
        mon_en   = 1'b0;
        rst      = 1'b1;
        busy     = 1'b0;
        pow_ack  = 1'b0;
        ifc.cmd_valid     = 1'b0;
        ifc.cmd_on        = 1'b0;
        ifc.cmd_boot_addr = '0;
        ifc.cmd_byp       = 1'b0;
        e_addr = ADDR_DEF;
        e_byp  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (snap() === mk(3'd0, 1'b0, 1'b0)) n_pass++;
        else $display("FAIL reset_state: got=%h, required %h", snap(), mk(3'd0, 1'b0, 1'b0));
        prev   = mk(3'd0, 1'b0, 1'b0);
        mon_en = 1'b1;
        rst    = 1'b0;

        // Power-up with boot address A, bypass set
        e_addr = ADDR_A; e_byp = 1'b1;
        issue(1'b1, ADDR_A, 1'b1, b);
        push(b,      3'd1, 1'b0, 1'b0);
        push(b + 16, 3'd2, 1'b0, 1'b0);
        push(b + 24, 3'd3, 1'b1, 1'b0);
        push(b + 25, 3'd3, 1'b0, 1'b0);
        repeat (30) @(posedge clk);

        // Redundant on in RUN: done only, latched address/bypass untouched
        issue(1'b1, 64'hDEAD_BEEF_0000_0000, 1'b0, b);
        push(b,     3'd3, 1'b1, 1'b0);
        push(b + 1, 3'd3, 1'b0, 1'b0);
        repeat (4) @(posedge clk);

        // Orderly power-down, cluster idle
        issue(1'b0, '0, 1'b0, b);
        push(b,      3'd4, 1'b0, 1'b0);
        push(b + 2,  3'd5, 1'b0, 1'b0);
        push(b + 3,  3'd6, 1'b0, 1'b0);
        push(b + 19, 3'd0, 1'b1, 1'b0);
        push(b + 20, 3'd0, 1'b0, 1'b0);
        repeat (25) @(posedge clk);

        // Redundant off in OFF
        issue(1'b0, 64'h1234, 1'b0, b);
        push(b,     3'd0, 1'b1, 1'b0);
        push(b + 1, 3'd0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);

        // Power-up with address B, bypass clear
        e_addr = ADDR_B; e_byp = 1'b0;
        issue(1'b1, ADDR_B, 1'b0, b);
        push(b,      3'd1, 1'b0, 1'b0);
        push(b + 16, 3'd2, 1'b0, 1'b0);
        push(b + 24, 3'd3, 1'b1, 1'b0);
        push(b + 25, 3'd3, 1'b0, 1'b0);
        repeat (30) @(posedge clk);

        // Power-down with busy stuck high: drain timeout sets err
        busy = 1'b1;
        issue(1'b0, '0, 1'b0, b);
        push(b,        3'd4, 1'b0, 1'b0);
        push(b + 1024, 3'd5, 1'b0, 1'b1);
        push(b + 1025, 3'd6, 1'b0, 1'b1);
        push(b + 1041, 3'd0, 1'b1, 1'b1);
        push(b + 1042, 3'd0, 1'b0, 1'b1);
        repeat (1050) @(posedge clk);
        busy = 1'b0;

        // Next accepted on clears err
        e_addr = ADDR_A; e_byp = 1'b1;
        issue(1'b1, ADDR_A, 1'b1, b);
        push(b,      3'd1, 1'b0, 1'b0);
        push(b + 16, 3'd2, 1'b0, 1'b0);
        push(b + 24, 3'd3, 1'b1, 1'b0);
        push(b + 25, 3'd3, 1'b0, 1'b0);
        repeat (30) @(posedge clk);

        issue(1'b0, '0, 1'b0, b);
        push(b,      3'd4, 1'b0, 1'b0);
        push(b + 2,  3'd5, 1'b0, 1'b0);
        push(b + 3,  3'd6, 1'b0, 1'b0);
        push(b + 19, 3'd0, 1'b1, 1'b0);
        push(b + 20, 3'd0, 1'b0, 1'b0);
        repeat (25) @(posedge clk);

        // Reset asserted mid-cycle during RST_HOLD (spec cycle 20)
        e_addr = ADDR_C; e_byp = 1'b1;
        issue(1'b1, ADDR_C, 1'b1, b);
        push(b,      3'd1, 1'b0, 1'b0);
        push(b + 16, 3'd2, 1'b0, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        rst    = 1'b1;
        e_addr = ADDR_DEF; e_byp = 1'b0;
        push(b + 19, 3'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);

        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL pending_expectations: got=%0d left, required 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
